// File: rtl/cnt_ctrl_if.sv
// Command/status bundle between upstream sequencing logic and the cnt_ctrl run controller.
interface cnt_ctrl_if #(
   parameter int CNT_W = 4,
   parameter int DIV_W = 3
);
   logic             start;
   logic             stop;
   logic             clr;
   logic [DIV_W-1:0] div;
   logic [CNT_W-1:0] limit;
   logic             repeat_en;
   logic [CNT_W-1:0] cnt;
   logic             tick;
   logic             wrap;
   logic             busy;
   logic             done;
   logic [1:0]       state;

   modport master (
      output start, stop, clr, div, limit, repeat_en,
      input  cnt, tick, wrap, busy, done, state
   );

   modport slave (
      input  start, stop, clr, div, limit, repeat_en,
      output cnt, tick, wrap, busy, done, state
   );
endinterface

// File: rtl/cnt_ctrl.sv
// Run controller: prescaler-gated counter sequenced by an IDLE/RUN/PAUSE/DONE FSM.
// The prescaler yields a one-cycle advance enable; no derived clocks.
module cnt_ctrl #(
   parameter int CNT_W = 4,
   parameter int DIV_W = 3
) (
   input logic        clk,
   input logic        rst,
   cnt_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10,
      DONE  = 2'b11
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_next;
   logic [DIV_W-1:0] presc_q, presc_d;
   logic             tick_q, tick_d;
   logic             wrap_q, wrap_d;
   logic             at_limit;

   // Using >= rather than == keeps a live decrease of limit from overshooting.
   assign at_limit = (cnt_q >= bus.limit);
   assign cnt_next = at_limit ? '0 : cnt_q + 1'b1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         presc_q <= '0;
         tick_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         presc_q <= presc_d;
         tick_q  <= tick_d;
         wrap_q  <= wrap_d;
      end
   end

   // Command priority is clr > stop > start > advance.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      presc_d = presc_q;
      tick_d  = 1'b0;
      wrap_d  = 1'b0;
      if (bus.clr) begin
         state_d = IDLE;
         cnt_d   = '0;
         presc_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  state_d = RUN;
                  cnt_d   = '0;
                  presc_d = '0;
               end
            end
            RUN: begin
               if (bus.stop) begin
                  state_d = PAUSE;
               end else if (presc_q >= bus.div) begin
                  cnt_d   = cnt_next;
                  presc_d = '0;
                  tick_d  = 1'b1;
                  wrap_d  = at_limit;
                  if (!bus.repeat_en && (cnt_next == bus.limit)) begin
                     state_d = DONE;
                  end
               end else begin
                  presc_d = presc_q + 1'b1;
               end
            end
            PAUSE: begin
               if (bus.start) begin
                  state_d = RUN;
               end
            end
            DONE: begin
               if (bus.start) begin
                  state_d = RUN;
                  cnt_d   = '0;
                  presc_d = '0;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   assign bus.cnt   = cnt_q;
   assign bus.tick  = tick_q;
   assign bus.wrap  = wrap_q;
   assign bus.busy  = (state_q == RUN);
   assign bus.done  = (state_q == DONE);
   assign bus.state = state_q;

endmodule

// File: tb/tb_cnt_ctrl.sv
// Self-checking bench for cnt_ctrl: vector table, directed corner sequences,
// then randomized commands checked against a cycle-level reference model.
module tb_cnt_ctrl;

   localparam int CNT_W = 4;
   localparam int DIV_W = 3;
   localparam int S_IDLE  = 0;
   localparam int S_RUN   = 1;
   localparam int S_PAUSE = 2;
   localparam int S_DONE  = 3;

   logic clk;
   logic rst;

   cnt_ctrl_if #(.CNT_W(CNT_W), .DIV_W(DIV_W)) bus ();

   cnt_ctrl #(.CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic             start;
      logic             stop;
      logic             clr;
      logic [DIV_W-1:0] div;
      logic [CNT_W-1:0] limit;
      logic             rpt;
      logic [CNT_W-1:0] expCnt;
      logic             expTick;
      logic             expWrap;
      logic [1:0]       expState;
   } vec_t;

   vec_t vecs[19];

   int nCompared   = 0;
   int nMismatched = 0;

   logic [DIV_W-1:0] curDiv;
   logic [CNT_W-1:0] curLimit;
   logic             curRpt;

   int mState;
   int mCnt;
   int mPresc;
   bit mTick;
   bit mWrap;

   task automatic applyStimulus(input logic s, input logic sp, input logic c);
      bus.start     = s;
      bus.stop      = sp;
      bus.clr       = c;
      bus.div       = curDiv;
      bus.limit     = curLimit;
      bus.repeat_en = curRpt;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic checkOutput(input string name, input logic [CNT_W-1:0] eCnt,
                              input logic eTick, input logic eWrap, input logic [1:0] eState);
      logic [CNT_W+5:0] act;
      logic [CNT_W+5:0] exp;
      act = {bus.cnt, bus.tick, bus.wrap, bus.busy, bus.done, bus.state};
      exp = {eCnt, eTick, eWrap, (eState == 2'd1), (eState == 2'd3), eState};
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got cnt=%0d tick=%b wrap=%b busy=%b done=%b state=%0d, want cnt=%0d tick=%b wrap=%b busy=%b done=%b state=%0d",
                  name, bus.cnt, bus.tick, bus.wrap, bus.busy, bus.done, bus.state,
                  eCnt, eTick, eWrap, (eState == 2'd1), (eState == 2'd3), eState);
      end
   endtask

   // Reference behaviour: one call per clock edge, written from the command rules.
   task automatic modelStep(input bit s, input bit sp, input bit c);
      int nextCnt;
      bit wrapNow;
      mTick = 0;
      mWrap = 0;
      if (c) begin
         mState = S_IDLE;
         mCnt   = 0;
         mPresc = 0;
      end else if (mState == S_IDLE || mState == S_DONE) begin
         if (s) begin
            mState = S_RUN;
            mCnt   = 0;
            mPresc = 0;
         end
      end else if (mState == S_PAUSE) begin
         if (s) mState = S_RUN;
      end else if (!sp) begin
         if (mPresc >= int'(curDiv)) begin
            wrapNow = (mCnt >= int'(curLimit));
            nextCnt = wrapNow ? 0 : (mCnt + 1) % (1 << CNT_W);
            mCnt    = nextCnt;
            mPresc  = 0;
            mTick   = 1;
            mWrap   = wrapNow;
            if (!curRpt && nextCnt == int'(curLimit)) mState = S_DONE;
         end else begin
            mPresc = mPresc + 1;
         end
      end else begin
         mState = S_PAUSE;
      end
   endtask

   task automatic randomStep(input bit s, input bit sp, input bit c);
      applyStimulus(s, sp, c);
      modelStep(s, sp, c);
      checkOutput("random", mCnt[CNT_W-1:0], mTick, mWrap, mState[1:0]);
   endtask

   initial begin
      vecs[0]  = '{0,0,1, 0,3,1, 0,0,0,0};
      vecs[1]  = '{1,0,0, 0,3,1, 0,0,0,1};
      vecs[2]  = '{0,0,0, 0,3,1, 1,1,0,1};
      vecs[3]  = '{0,0,0, 0,3,1, 2,1,0,1};
      vecs[4]  = '{0,0,0, 0,3,1, 3,1,0,1};
      vecs[5]  = '{0,0,0, 0,3,1, 0,1,1,1};
      vecs[6]  = '{0,0,0, 0,3,1, 1,1,0,1};
      vecs[7]  = '{0,1,0, 0,3,1, 1,0,0,2};
      vecs[8]  = '{0,1,0, 0,3,1, 1,0,0,2};
      vecs[9]  = '{1,0,0, 0,3,1, 1,0,0,1};
      vecs[10] = '{0,0,0, 0,3,1, 2,1,0,1};
      vecs[11] = '{1,0,1, 0,3,1, 0,0,0,0};
      vecs[12] = '{1,0,0, 0,3,1, 0,0,0,1};
      vecs[13] = '{0,0,0, 0,0,0, 0,1,1,3};
      vecs[14] = '{0,0,0, 0,0,0, 0,0,0,3};
      vecs[15] = '{1,0,0, 0,2,0, 0,0,0,1};
      vecs[16] = '{0,0,0, 0,2,0, 1,1,0,1};
      vecs[17] = '{0,0,0, 0,2,0, 2,1,0,3};
      vecs[18] = '{0,0,0, 0,2,0, 2,0,0,3};

      rst = 1'b0;
      curDiv = '0; curLimit = '0; curRpt = 1'b0;
      bus.start = 1'b0; bus.stop = 1'b0; bus.clr = 1'b0;
      bus.div = '0; bus.limit = '0; bus.repeat_en = 1'b0;
      @(negedge clk);
      checkOutput("reset", 0, 0, 0, 2'd0);
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 19; i++) begin
         curDiv = vecs[i].div; curLimit = vecs[i].limit; curRpt = vecs[i].rpt;
         applyStimulus(vecs[i].start, vecs[i].stop, vecs[i].clr);
         checkOutput($sformatf("vec%0d", i), vecs[i].expCnt, vecs[i].expTick,
                     vecs[i].expWrap, vecs[i].expState);
      end

      // One-shot, div=4: an advance every 5 edges, DONE together with cnt=limit.
      curDiv = 3'd4; curLimit = 4'd9; curRpt = 1'b0;
      applyStimulus(0, 0, 1);
      applyStimulus(1, 0, 0);
      checkOutput("oneshot_start", 0, 0, 0, 2'd1);
      for (int k = 1; k <= 9; k++) begin
         for (int j = 0; j < 4; j++) applyStimulus(0, 0, 0);
         checkOutput("oneshot_hold", 4'(k - 1), 0, 0, 2'd1);
         applyStimulus(0, 0, 0);
         checkOutput("oneshot_step", 4'(k), 1, 0, (k == 9) ? 2'd3 : 2'd1);
      end
      for (int j = 0; j < 3; j++) applyStimulus(0, 0, 0);
      checkOutput("oneshot_done_hold", 9, 0, 0, 2'd3);

      // Stop lands on an advance-due edge; resume keeps the saturated prescaler.
      curDiv = 3'd2; curLimit = 4'd9; curRpt = 1'b1;
      applyStimulus(0, 0, 1);
      applyStimulus(1, 0, 0);
      for (int j = 0; j < 6; j++) applyStimulus(0, 0, 0);
      checkOutput("pause_pre", 2, 1, 0, 2'd1);
      applyStimulus(0, 0, 0);
      applyStimulus(0, 0, 0);
      applyStimulus(0, 1, 0);
      checkOutput("pause_enter", 2, 0, 0, 2'd2);
      for (int j = 0; j < 10; j++) begin
         applyStimulus(0, 0, 0);
         checkOutput("pause_hold", 2, 0, 0, 2'd2);
      end
      applyStimulus(1, 0, 0);
      checkOutput("pause_resume", 2, 0, 0, 2'd1);
      applyStimulus(0, 0, 0);
      checkOutput("pause_advance", 3, 1, 0, 2'd1);

      // Live limit decrease below the current count wraps without overshoot.
      for (int r = 1; r >= 0; r--) begin
         curDiv = 3'd0; curLimit = 4'd12; curRpt = 1'(r);
         applyStimulus(0, 0, 1);
         applyStimulus(1, 0, 0);
         for (int j = 0; j < 7; j++) applyStimulus(0, 0, 0);
         checkOutput("lower_pre", 7, 1, 0, 2'd1);
         curLimit = 4'd5;
         applyStimulus(0, 0, 0);
         checkOutput(r ? "lower_wrap_rpt" : "lower_wrap_oneshot", 0, 1, 1, 2'd1);
      end

      // Asynchronous reset mid-count, then restart from zero.
      curDiv = 3'd0; curLimit = 4'd12; curRpt = 1'b1;
      applyStimulus(0, 0, 1);
      applyStimulus(1, 0, 0);
      for (int j = 0; j < 6; j++) applyStimulus(0, 0, 0);
      checkOutput("rst_pre", 6, 1, 0, 2'd1);
      #1 rst = 1'b0;
      #1 checkOutput("rst_async", 0, 0, 0, 2'd0);
      @(negedge clk);
      rst = 1'b1;
      applyStimulus(1, 0, 0);
      checkOutput("rst_restart", 0, 0, 0, 2'd1);
      applyStimulus(0, 0, 0);
      checkOutput("rst_restart_step", 1, 1, 0, 2'd1);

      // Randomized commands and configuration against the reference model.
      curDiv = 3'd1; curLimit = 4'd6; curRpt = 1'b1;
      randomStep(0, 0, 1);
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(0, 9) == 0) begin
            curDiv   = DIV_W'($urandom_range(0, 3));
            curLimit = CNT_W'($urandom_range(0, 15));
            curRpt   = 1'($urandom_range(0, 1));
         end
         randomStep($urandom_range(0, 9) < 2, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 39) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/cnt_ctrl.md
# cnt_ctrl

Run controller for the team's synchronous counter datapath: a programmable prescaler and counter sequenced by a 4-state FSM, on one clock with no derived clocks. The prescaler produces a single-cycle advance enable in place of a divided clock. Upstream logic drives start/stop/clear commands and a terminal value. The block reports count, advance tick, wrap and completion status.

## Interface
- CNT_W, default 4: counter width.
- DIV_W, default 3: prescaler width; advance period is div+1 clocks.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  command pulse: begin, resume or restart.
- stop  in  1  command pulse: pause a running count.
- clr  in  1  command pulse: abort to IDLE and zero the counter.
- div  in  DIV_W  prescale value, sampled every cycle.
- limit  in  CNT_W  terminal count, sampled every cycle.
- repeat  in  1  1 = wrap and continue; 0 = one-shot, stop at limit.
- cnt  out  CNT_W  current count (registered).
- tick  out  1  one-cycle pulse, high in the cycle cnt shows a newly advanced value.
- wrap  out  1  one-cycle pulse, high in the cycle cnt shows 0 after a wrap.
- busy  out  1  state == RUN.
- done  out  1  state == DONE.
- state  out  2  IDLE=00, RUN=01, PAUSE=10, DONE=11.

## Operation
- Internal prescaler register presc (DIV_W bits).
- Per-cycle command priority: clr > stop > start > advance.
- clr, any state: state←IDLE, cnt←0, presc←0, no tick or wrap.
- IDLE: start → RUN, cnt←0, presc←0. stop is ignored.
- RUN: stop → PAUSE. presc and cnt hold, and there is no advance that cycle even if one was due. start is ignored.
- RUN, no command: if presc ≥ div, an advance occurs and presc←0. Otherwise presc←presc+1.
- Advance rules:
  - next = (cnt ≥ limit) ? 0 : cnt+1.
  - cnt←next and tick←1.
  - If cnt ≥ limit, wrap←1.
  - If repeat=0 and next == limit, state←DONE on the same edge.
  - The ≥ comparisons make a live decrease of div or limit safe: no overshoot, and the next advance wraps.
- PAUSE: start → RUN, resuming with the retained presc and cnt. stop is ignored.
- DONE: cnt holds at limit. start → RUN, cnt←0, presc←0. stop is ignored.
- Edge cases:
  - repeat=0, limit=0: the first advance keeps cnt at 0, pulses wrap and enters DONE.
  - repeat=1, limit=0: cnt stays 0, with tick and wrap on every advance.
- Changing repeat while in RUN takes effect at the next advance.
- All arithmetic is modulo 2^width. cnt never exceeds max(limit, its value at a limit decrease).

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE, cnt=0, presc=0, tick=0, wrap=0, busy=0, done=0.
- Let E0 be the edge that samples start. busy rises the cycle after E0.
- First advance edge is E0+div+1; later advances follow every div+1 edges.
- tick, wrap and the cnt update are visible together in the cycle after the advance edge; tick and wrap last exactly one cycle.
- done and busy follow the state register with zero additional latency. In one-shot mode, done rises in the same cycle cnt shows limit.
- stop on an advance-due edge: advance suppressed. After resume, the first advance is due at the first edge where presc ≥ div.
- Reset asserted mid-operation clears everything immediately; there is no pending-command memory.
- Commands are level-sampled each edge; a start held for multiple cycles in RUN is harmless.

## Test plan
- div=4, limit=9, repeat=0, start pulse:
  - cnt steps 1..9 at edges E0+5, +10, …, +45, each step with one tick.
  - done=1 and busy=0 from cnt=9 onward; cnt holds at 9.
- div=0, limit=3, repeat=1:
  - cnt sequence 1,2,3,0,1 on consecutive cycles.
  - wrap high only when cnt=0; tick high every cycle.
- div=2, run to cnt=2, then stop on an advance-due edge:
  - state=PAUSE, cnt stays 2 for 10 cycles.
  - start: the next advance to 3 comes on the first edge after resume where presc ≥ 2.
- clr and start asserted together in RUN: state=IDLE, cnt=0, busy=0. start alone one cycle later → RUN.
- limit=12 while cnt=7 in RUN, then limit lowered to 5, repeat=1: next advance gives cnt=0 with a wrap pulse. With repeat=0 the same advance gives cnt=0 and no DONE.
- Assert rst mid-count with cnt=6: all outputs zero and state=IDLE within the same cycle, before any clock edge. After release, start restarts from 0.
